// File: rtl/sram_bridge_pkg.sv
// Shared helpers for the subservient SRAM bridge.
// Holds the clog2 function and the derived-width helpers. The interface,
// the write-combining buffer and the top all use them, so the address split
// is computed the same way everywhere:
//   byte address = { bank (BANKW) | word (BANK_AW) | lane (OFFW) }
package sram_bridge_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Number of byte lanes in one macro word.
    function automatic int byte_lanes(input int dw);
        return dw / 8;
    endfunction

    // Width of the byte-lane field at the bottom of a byte address.
    function automatic int off_width(input int dw);
        return clog2(dw / 8);
    endfunction

    // Width of the bank-select field at the top of a byte address.
    function automatic int bank_width(input int aw, input int dw, input int bank_aw);
        return aw - off_width(dw) - bank_aw;
    endfunction

    function automatic int num_banks(input int aw, input int dw, input int bank_aw);
        return 1 << bank_width(aw, dw, bank_aw);
    endfunction

endpackage

// File: rtl/subservient_sram_bridge_if.sv
// Bundle between the subservient core / bank macros and the bridge.
// Core side : waddr, wdata, wen (byte writes), raddr, ren, rdata (byte reads),
//             pending (write buffer holds unflushed bytes).
// Macro side: csb0, wmask0, addr0, din0 (port 0, writes only),
//             csb1, addr1, dout1 (port 1, reads only; bank b at [b*DW +: DW]).
// Modport slave is the bridge; modport master is everything around it.
interface subservient_sram_bridge_if
    import sram_bridge_pkg::*;
#(
    parameter int AW      = 13,
    parameter int DW      = 32,
    parameter int BANK_AW = 8
);
    localparam int BW     = byte_lanes(DW);
    localparam int NBANKS = num_banks(AW, DW, BANK_AW);

    logic [AW-1:0]        waddr;
    logic [7:0]           wdata;
    logic                 wen;
    logic [AW-1:0]        raddr;
    logic                 ren;
    logic [7:0]           rdata;
    logic [NBANKS-1:0]    csb0;
    logic [BW-1:0]        wmask0;
    logic [BANK_AW-1:0]   addr0;
    logic [DW-1:0]        din0;
    logic [NBANKS-1:0]    csb1;
    logic [BANK_AW-1:0]   addr1;
    logic [NBANKS*DW-1:0] dout1;
    logic                 pending;

    modport slave (
        input  waddr, wdata, wen, raddr, ren, dout1,
        output rdata, csb0, wmask0, addr0, din0, csb1, addr1, pending
    );

    modport master (
        output waddr, wdata, wen, raddr, ren, dout1,
        input  rdata, csb0, wmask0, addr0, din0, csb1, addr1, pending
    );

endinterface

// File: rtl/sram_wc_buffer.sv
// Write-combining buffer for the SRAM bridge.
// Collects byte writes to one word and hands the word out as a single masked
// macro write (flush). Also answers forwarding lookups for reads.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wen, waddr, wdata   byte write from the core
//   raddr               byte read address (forwarding lookup)
//   flush               buffer contents must be written to the macro this cycle
//   buf_word/data/mask  buffer contents, driven straight onto macro port 0
//   pending             buffer holds unflushed bytes
//   fwd_hit, fwd_byte   read address hits a buffered byte, and that byte
module sram_wc_buffer
    import sram_bridge_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 32
)
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wen,
    input  logic [AW-1:0]                  waddr,
    input  logic [7:0]                     wdata,
    input  logic [AW-1:0]                  raddr,
    output logic                           flush,
    output logic [AW-off_width(DW)-1:0]    buf_word,
    output logic [DW-1:0]                  buf_data,
    output logic [byte_lanes(DW)-1:0]      buf_mask,
    output logic                           pending,
    output logic                           fwd_hit,
    output logic [7:0]                     fwd_byte
);
    localparam int BW   = byte_lanes(DW);
    localparam int OFFW = off_width(DW);
    localparam int WAW  = AW - OFFW;
    localparam int LW   = (OFFW > 0) ? OFFW : 1;

    logic           valid_reg, valid_next;
    logic [WAW-1:0] word_reg,  word_next;
    logic [DW-1:0]  data_reg,  data_next;
    logic [BW-1:0]  mask_reg,  mask_next;

    logic [WAW-1:0] w_word, r_word;
    logic [LW-1:0]  w_lane, r_lane;
    logic           merge;

    assign w_word = waddr[AW-1:OFFW];
    assign r_word = raddr[AW-1:OFFW];

    generate
        if (OFFW > 0) begin : g_lane
            assign w_lane = waddr[OFFW-1:0];
            assign r_lane = raddr[OFFW-1:0];
        end else begin : g_single_lane
            assign w_lane = '0;
            assign r_lane = '0;
        end
    endgenerate

    // A full word is never merged into: it goes out this cycle and any write
    // to the same word starts a fresh buffer.
    assign merge = wen && valid_reg && (word_reg == w_word) && !(&mask_reg);
    // Anything valid that is not being merged into leaves this cycle.
    assign flush = valid_reg && !merge;

    always_comb begin
        valid_next = valid_reg;
        word_next  = word_reg;
        data_next  = data_reg;
        mask_next  = mask_reg;
        if (wen) begin
            if (merge) begin
                data_next[w_lane*8 +: 8] = wdata;
                mask_next[w_lane]        = 1'b1;
            end else begin
                valid_next = 1'b1;
                word_next  = w_word;
                data_next  = {BW{wdata}};
                mask_next  = BW'(1) << w_lane;
            end
        end else if (flush) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            word_reg  <= '0;
            data_reg  <= '0;
            mask_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            word_reg  <= word_next;
            data_reg  <= data_next;
            mask_reg  <= mask_next;
        end
    end

    // Lookup uses the buffer as held at the start of the cycle, so a
    // same-cycle write to the same byte is not seen by the read.
    assign fwd_hit  = valid_reg && (word_reg == r_word) && mask_reg[r_lane];
    assign fwd_byte = data_reg[r_lane*8 +: 8];

    assign buf_word = word_reg;
    assign buf_data = data_reg;
    assign buf_mask = mask_reg;
    assign pending  = valid_reg;

endmodule

// File: rtl/subservient_sram_bridge.sv
// Bridge from the subservient core's byte-serial SRAM port to NBANKS banks of
// 1rw1r word-wide SRAM macros. Port 0 of each bank takes writes (combined in
// sram_wc_buffer), port 1 takes reads. Read data returns the cycle after the
// read strobe, taken from the buffer when it holds the byte, else from the
// macro.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   bus           subservient_sram_bridge_if.slave (core and macro signals)
module subservient_sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int AW      = 13,
    parameter int DW      = 32,
    parameter int BANK_AW = 8
)
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    subservient_sram_bridge_if.slave bus
);
    localparam int BW     = byte_lanes(DW);
    localparam int OFFW   = off_width(DW);
    localparam int BANKW  = bank_width(AW, DW, BANK_AW);
    localparam int NBANKS = num_banks(AW, DW, BANK_AW);
    localparam int WAW    = AW - OFFW;
    localparam int LW     = (OFFW > 0) ? OFFW : 1;
    localparam int BIW    = (BANKW > 0) ? BANKW : 1;

    logic           flush;
    logic [WAW-1:0] buf_word;
    logic [DW-1:0]  buf_data;
    logic [BW-1:0]  buf_mask;
    logic           pending;
    logic           fwd_hit;
    logic [7:0]     fwd_byte;

    sram_wc_buffer #(
        .AW (AW),
        .DW (DW)
    ) u_wc_buffer (
        .clk      (i_clk),
        .rst      (i_rst),
        .wen      (bus.wen),
        .waddr    (bus.waddr),
        .wdata    (bus.wdata),
        .raddr    (bus.raddr),
        .flush    (flush),
        .buf_word (buf_word),
        .buf_data (buf_data),
        .buf_mask (buf_mask),
        .pending  (pending),
        .fwd_hit  (fwd_hit),
        .fwd_byte (fwd_byte)
    );

    // ---------------- bank / lane decode ----------------
    logic [BIW-1:0] flush_bank, rd_bank;
    logic [LW-1:0]  rd_lane;

    generate
        if (BANKW > 0) begin : g_bank
            assign flush_bank = buf_word[WAW-1:BANK_AW];
            assign rd_bank    = bus.raddr[AW-1:AW-BANKW];
        end else begin : g_single_bank
            assign flush_bank = '0;
            assign rd_bank    = '0;
        end
        if (OFFW > 0) begin : g_lane
            assign rd_lane = bus.raddr[OFFW-1:0];
        end else begin : g_single_lane
            assign rd_lane = '0;
        end
    endgenerate

    // ---------------- port drive ----------------
    assign bus.addr0   = buf_word[BANK_AW-1:0];
    assign bus.wmask0  = buf_mask;
    assign bus.din0    = buf_data;
    assign bus.addr1   = bus.raddr[OFFW +: BANK_AW];
    assign bus.pending = pending;

    logic [DW-1:0] bank_dout [NBANKS];

    // Chip selects are gated by reset directly so they go inactive the moment
    // reset rises, even while the core is still strobing a read.
    generate
        for (genvar gi = 0; gi < NBANKS; gi++) begin : g_banks
            assign bus.csb0[gi]  = i_rst | ~(flush   & (flush_bank == BIW'(gi)));
            assign bus.csb1[gi]  = i_rst | ~(bus.ren & (rd_bank    == BIW'(gi)));
            assign bank_dout[gi] = bus.dout1[gi*DW +: DW];
        end
    endgenerate

    // ---------------- read return ----------------
    logic           rd_valid_reg;
    logic           rd_fwd_reg;
    logic [7:0]     rd_fwd_byte_reg;
    logic [BIW-1:0] rd_bank_reg;
    logic [LW-1:0]  rd_lane_reg;
    logic [7:0]     rdata_hold_reg;
    logic [DW-1:0]  rd_word;
    logic [7:0]     rdata_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_valid_reg    <= 1'b0;
            rd_fwd_reg      <= 1'b0;
            rd_fwd_byte_reg <= '0;
            rd_bank_reg     <= '0;
            rd_lane_reg     <= '0;
            rdata_hold_reg  <= '0;
        end else begin
            rd_valid_reg <= bus.ren;
            if (bus.ren) begin
                rd_fwd_reg      <= fwd_hit;
                rd_fwd_byte_reg <= fwd_byte;
                rd_bank_reg     <= rd_bank;
                rd_lane_reg     <= rd_lane;
            end
            // The macro output is only trusted in the cycle after its read,
            // so the returned byte is kept here for the idle cycles that follow.
            if (rd_valid_reg) begin
                rdata_hold_reg <= rdata_next;
            end
        end
    end

    always_comb begin
        rd_word    = bank_dout[rd_bank_reg];
        rdata_next = rdata_hold_reg;
        if (rd_valid_reg) begin
            rdata_next = rd_fwd_reg ? rd_fwd_byte_reg : rd_word[rd_lane_reg*8 +: 8];
        end
    end

    assign bus.rdata = rdata_next;

endmodule

// File: tb/tb_subservient_sram_bridge.sv
// Bench for subservient_sram_bridge: bank macro models on both ports, directed
// cases, then randomized byte traffic checked against a flat byte-array model
// of the whole memory.
module tb_subservient_sram_bridge;
    localparam int AW      = 13;
    localparam int DW      = 32;
    localparam int BANK_AW = 8;
    localparam int NBANKS  = 8;
    localparam int WORDS   = 256;
    localparam int MEMSIZE = 8192;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subservient_sram_bridge_if #(.AW(AW), .DW(DW), .BANK_AW(BANK_AW)) bus ();

    subservient_sram_bridge #(.AW(AW), .DW(DW), .BANK_AW(BANK_AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // ---------------- bank macro models ----------------
    logic [DW-1:0] mem [NBANKS][WORDS];

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    initial begin
        for (int b = 0; b < NBANKS; b++)
            for (int w = 0; w < WORDS; w++)
                for (int l = 0; l < 4; l++)
                    mem[b][w][l*8 +: 8] <= init_byte(b * 1024 + w * 4 + l);
        bus.dout1 <= '0;
    end

    // Port 1 reads return the pre-write contents when port 0 writes the same
    // word at the same edge.
    always @(posedge clk) begin
        for (int b = 0; b < NBANKS; b++) begin
            if (!bus.csb1[b]) bus.dout1[b*DW +: DW] <= mem[b][bus.addr1];
            if (!bus.csb0[b])
                for (int l = 0; l < 4; l++)
                    if (bus.wmask0[l]) mem[b][bus.addr0][l*8 +: 8] <= bus.din0[l*8 +: 8];
        end
    end

    // ---------------- reference model and checking ----------------
    logic [7:0] sb [MEMSIZE];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic set_in(input logic wen, input logic [AW-1:0] wa, input logic [7:0] wd,
                          input logic ren, input logic [AW-1:0] ra);
        bus.wen   = wen;
        bus.waddr = wa;
        bus.wdata = wd;
        bus.ren   = ren;
        bus.raddr = ra;
    endtask

    // Same as set_in, and the write is recorded in the reference model.
    task automatic drv(input logic wen, input logic [AW-1:0] wa, input logic [7:0] wd,
                       input logic ren, input logic [AW-1:0] ra);
        set_in(wen, wa, wd, ren, ra);
        if (wen) sb[wa] = wd;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [10:0] hot [4];
        hot[0] = 11'h001; hot[1] = 11'h7FF; hot[2] = 11'h100; hot[3] = 11'h101;
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, MEMSIZE - 1));
        return {hot[$urandom_range(0, 3)], 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        logic       have_exp;
        logic [7:0] exp_rd;
        logic       r_wen, r_ren;
        logic [AW-1:0] r_wa, r_ra;
        logic [7:0] r_wd;

        for (int a = 0; a < MEMSIZE; a++) sb[a] = init_byte(a);

        // ---- reset state (read strobe held high to prove csb1 is gated) ----
        rst = 1'b1;
        set_in(1'b0, '0, '0, 1'b1, '0);
        #3;
        chk("rst_csb0", bus.csb0, 8'hFF);
        chk("rst_csb1", bus.csb1, 8'hFF);
        chk("rst_rdata", bus.rdata, 8'h00);
        chk("rst_pending", bus.pending, 1'b0);
        nxt(); nxt();
        rst = 1'b0;

        // ---- reset while buffer holds bytes, flush and read in flight ----
        set_in(1'b1, 13'h030, 8'h77, 1'b0, '0);
        mid(); chk("r_pend0", bus.pending, 1'b0); nxt();
        set_in(1'b1, 13'h031, 8'h88, 1'b1, 13'h100);
        mid(); chk("r_merge_csb0", bus.csb0, 8'hFF); nxt();
        set_in(1'b0, '0, '0, 1'b1, 13'h1200);
        mid();
        chk("r_rdata_pre", bus.rdata, init_byte(13'h100));
        chk("r_pend_pre", bus.pending, 1'b1);
        chk("r_csb0_pre", bus.csb0, 8'hFE);
        chk("r_csb1_pre", bus.csb1, 8'hEF);
        #1 rst = 1'b1;
        #1;
        chk("r_csb0_rst", bus.csb0, 8'hFF);
        chk("r_csb1_rst", bus.csb1, 8'hFF);
        chk("r_rdata_rst", bus.rdata, 8'h00);
        chk("r_pend_rst", bus.pending, 1'b0);
        nxt();
        rst = 1'b0;
        set_in(1'b0, '0, '0, 1'b1, 13'h030);
        mid(); nxt();
        set_in(1'b0, '0, '0, 1'b1, 13'h031);
        mid(); chk("r_rd030", bus.rdata, init_byte(13'h030)); nxt();
        set_in(1'b0, '0, '0, 1'b0, '0);
        mid(); chk("r_rd031", bus.rdata, init_byte(13'h031)); nxt();

        // ---- four bytes into one word, then a write to the full word ----
        drv(1'b1, 13'h004, 8'h11, 1'b0, '0); mid(); chk("w4_csb0", bus.csb0, 8'hFF); nxt();
        drv(1'b1, 13'h005, 8'h22, 1'b0, '0); mid(); chk("w5_csb0", bus.csb0, 8'hFF); nxt();
        drv(1'b1, 13'h006, 8'h33, 1'b0, '0); mid(); chk("w6_csb0", bus.csb0, 8'hFF); nxt();
        drv(1'b1, 13'h007, 8'h44, 1'b0, '0); mid(); chk("w7_csb0", bus.csb0, 8'hFF); nxt();
        drv(1'b1, 13'h004, 8'h55, 1'b0, '0);
        mid();
        chk("full_csb0", bus.csb0, 8'hFE);
        chk("full_addr0", bus.addr0, 8'h01);
        chk("full_wmask0", bus.wmask0, 4'hF);
        chk("full_din0", bus.din0, 32'h44332211);
        nxt();
        drv(1'b0, '0, '0, 1'b0, '0);
        mid();
        chk("fresh_csb0", bus.csb0, 8'hFE);
        chk("fresh_wmask0", bus.wmask0, 4'h1);
        chk("fresh_din0", bus.din0, 32'h55555555);
        chk("fresh_pend", bus.pending, 1'b1);
        nxt();
        mid(); chk("idle_pend", bus.pending, 1'b0); chk("idle_csb0", bus.csb0, 8'hFF); nxt();

        // ---- top address, single byte ----
        drv(1'b1, 13'h1FFF, 8'hA5, 1'b0, '0); mid(); chk("top_csb0_wr", bus.csb0, 8'hFF); nxt();
        drv(1'b0, '0, '0, 1'b0, '0);
        mid();
        chk("top_csb0", bus.csb0, 8'h7F);
        chk("top_addr0", bus.addr0, 8'hFF);
        chk("top_wmask0", bus.wmask0, 4'h8);
        chk("top_din0", bus.din0, 32'hA5A5A5A5);
        nxt();
        nxt();
        drv(1'b0, '0, '0, 1'b1, 13'h1FFF);
        mid(); chk("top_csb1", bus.csb1, 8'h7F); chk("top_addr1", bus.addr1, 8'hFF); nxt();
        drv(1'b0, '0, '0, 1'b0, '0);
        mid(); chk("top_rd", bus.rdata, 8'hA5); nxt();

        // ---- forwarding from a buffer being flushed ----
        drv(1'b1, 13'h010, 8'h5A, 1'b0, '0); mid(); nxt();
        drv(1'b0, '0, '0, 1'b1, 13'h010); mid(); chk("fwd_csb0", bus.csb0, 8'hFE); nxt();
        drv(1'b0, '0, '0, 1'b0, '0); mid(); chk("fwd_rd", bus.rdata, 8'h5A); nxt();
        mid(); chk("fwd_hold", bus.rdata, 8'h5A); nxt();
        drv(1'b1, 13'h018, 8'hC3, 1'b0, '0); mid(); nxt();
        drv(1'b0, '0, '0, 1'b1, 13'h019); mid(); nxt();
        drv(1'b0, '0, '0, 1'b0, '0); mid(); chk("unmasked_rd", bus.rdata, init_byte(13'h019)); nxt();

        // ---- same-cycle write is not forwarded ----
        drv(1'b1, 13'h050, 8'hAA, 1'b0, '0); mid(); nxt();
        drv(1'b1, 13'h050, 8'hBB, 1'b1, 13'h050); mid(); nxt();
        drv(1'b0, '0, '0, 1'b0, '0); mid(); chk("sameclk_rd", bus.rdata, 8'hAA); nxt();
        mid(); nxt();

        // ---- word change flushes the old word ----
        drv(1'b1, 13'h020, 8'h01, 1'b0, '0); mid(); nxt();
        drv(1'b1, 13'h420, 8'h02, 1'b0, '0);
        mid();
        chk("chg_csb0", bus.csb0, 8'hFE);
        chk("chg_addr0", bus.addr0, 8'h08);
        chk("chg_wmask0", bus.wmask0, 4'h1);
        chk("chg_din0", bus.din0, 32'h01010101);
        nxt();
        drv(1'b0, '0, '0, 1'b0, '0);
        mid();
        chk("chg_pend", bus.pending, 1'b1);
        chk("chg2_csb0", bus.csb0, 8'hFD);
        chk("chg2_addr0", bus.addr0, 8'h08);
        chk("chg2_din0", bus.din0, 32'h02020202);
        nxt();

        // ---- randomized traffic against the byte-array model ----
        have_exp = 1'b0;
        exp_rd   = '0;
        for (int i = 0; i < 10000; i++) begin
            r_wen = 1'($urandom_range(0, 1));
            r_ren = 1'($urandom_range(0, 1));
            r_wa  = rand_addr();
            r_ra  = rand_addr();
            r_wd  = 8'($urandom);
            set_in(r_wen, r_wa, r_wd, r_ren, r_ra);
            mid();
            if (have_exp) chk("rnd_rd", bus.rdata, exp_rd);
            if (r_ren) begin
                exp_rd   = sb[r_ra];
                have_exp = 1'b1;
            end
            if (r_wen) sb[r_wa] = r_wd;
            nxt();
        end
        set_in(1'b0, '0, '0, 1'b0, '0);
        mid();
        if (have_exp) chk("rnd_last", bus.rdata, exp_rd);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
